// File: rtl/wb_spi_mailbox.sv
// wb_spi_mailbox: Wishbone classic slave mailbox with TX/RX word FIFOs,
// control/status/scratch registers and pulse/irq outputs toward local logic.
// Optional build macro WB_SPI_MAILBOX_LOOPBACK_EN adds CTRL bit3 loopback
// (TX FIFO head moves straight into the RX FIFO while set).
module wb_spi_mailbox #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] ID_VALUE    = 32'h5350_4D42,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [25:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [31:0] tx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    input  logic [31:0] rx_tdata,
    output logic        soft_reset,
    output logic        start_pulse,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state, state_nxt;
    logic [1:0]      wait_cnt;
    logic            accept, wr_en, rd_en;
    logic [5:0]      idx;
    logic [31:0]     rd_now, rd_hold, scratch;
    logic            irq_en, tx_ovf, rx_ovf, loopback, lb_move;

    logic [31:0]     tx_mem [DEPTH];
    logic [31:0]     rx_mem [DEPTH];
    logic [AW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]   tx_cnt, rx_cnt;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
    logic            unused_adr;

    assign unused_adr = ^{wb_adr_i[25:8], wb_adr_i[1:0]};

    assign idx    = wb_adr_i[7:2];
    assign accept = wb_cyc_i & wb_stb_i & (state == S_IDLE);
    assign wr_en  = accept & wb_we_i;
    assign rd_en  = accept & ~wb_we_i;

    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign rx_empty = (rx_cnt == '0);

`ifdef WB_SPI_MAILBOX_LOOPBACK_EN
    // Loopback mode bit, written through CTRL bit3
    always_ff @(posedge clk) begin
        if (rst)
            loopback <= 1'b0;
        else if (wr_en && idx == 6'd1)
            loopback <= wb_dat_i[3];
    end
    assign lb_move = loopback & ~tx_empty & ~rx_full;
`else
    assign loopback = 1'b0;
    assign lb_move  = 1'b0;
`endif

    assign tx_tvalid = ~tx_empty & ~loopback;
    assign tx_tdata  = tx_mem[tx_rd];
    assign rx_tready = ~rx_full & ~loopback;
    assign irq       = irq_en & (~rx_empty | tx_ovf | rx_ovf);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign tx_pop      = (tx_tvalid & tx_tready) | lb_move;
    assign tx_push_req = wr_en & (idx == 6'd4);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign rx_pop_req  = rd_en & (idx == 6'd5);
    assign rx_pop      = rx_pop_req & ~rx_empty;
    assign rx_push     = lb_move | (rx_tvalid & rx_tready);

    // Bus FSM state and wait-state counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Next-state: accept, optional wait states (abortable by cyc drop), one ack cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
            S_WAIT: begin
                if (!wb_cyc_i)
                    state_nxt = S_IDLE;
                else if (wait_cnt == 2'd0)
                    state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered ack and read data; data is zero outside the ack cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= (state_nxt == S_ACK);
            wb_dat_o <= (state_nxt == S_ACK) ? ((state == S_IDLE) ? rd_now : rd_hold) : '0;
        end
    end

    // Read mux over the register map, evaluated on pre-access state
    always_comb begin
        rd_now = 32'hDEAD_BEEF;
        case (idx)
            6'd0: rd_now = ID_VALUE;
            6'd1: rd_now = {28'b0, loopback, irq_en, 2'b00};
            6'd2: rd_now = {8'(tx_cnt), 8'(rx_cnt), 12'h000, rx_ovf, tx_ovf, ~rx_empty, tx_full};
            6'd3: rd_now = scratch;
            6'd4: rd_now = '0;
            6'd5: rd_now = rx_empty ? '0 : rx_mem[rx_rd];
            default: rd_now = 32'hDEAD_BEEF;
        endcase
    end

    // Control registers, sticky flags and pulses; all commit at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hold     <= '0;
            scratch     <= '0;
            irq_en      <= 1'b0;
            tx_ovf      <= 1'b0;
            rx_ovf      <= 1'b0;
            soft_reset  <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            soft_reset  <= 1'b0;
            start_pulse <= 1'b0;
            if (accept)
                rd_hold <= rd_now;
            if (wr_en) begin
                case (idx)
                    6'd1: begin
                        soft_reset  <= wb_dat_i[0];
                        start_pulse <= wb_dat_i[1];
                        irq_en      <= wb_dat_i[2];
                    end
                    6'd2: begin
                        if (wb_dat_i[3]) rx_ovf <= 1'b0;
                        if (wb_dat_i[2]) tx_ovf <= 1'b0;
                    end
                    6'd3: scratch <= wb_dat_i;
                    default: ;
                endcase
            end
            if (tx_push_req && !tx_push)
                tx_ovf <= 1'b1;
            if (rx_pop_req && rx_empty)
                rx_ovf <= 1'b1;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr] <= wb_dat_i;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // RX FIFO storage; loopback feeds it from the TX head
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr] <= lb_move ? tx_mem[tx_rd] : rx_tdata;
    end

endmodule

// File: tb/tb_wb_spi_mailbox.sv
// tb_wb_spi_mailbox: directed and randomized bench for wb_spi_mailbox.
// Instance 0 uses WAIT_STATES=0 against a queue-based model; instance 1
// uses WAIT_STATES=2 for latency and abort behaviour.
module tb_wb_spi_mailbox;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] ID    = 32'h5350_4D42;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [25:0] adr [2];
    logic [31:0] wdat[2];
    logic [31:0] rdat[2];
    logic        ack [2];

    logic        tx_tvalid, tx_tready, rx_tvalid, rx_tready, soft_reset, start_pulse, irq;
    logic [31:0] tx_tdata, rx_tdata;
    logic        tx_tvalid_b, rx_tready_b, soft_reset_b, start_pulse_b, irq_b;
    logic [31:0] tx_tdata_b;
    logic        tx_tready_b = 1'b0;
    logic        rx_tvalid_b = 1'b0;
    logic [31:0] rx_tdata_b  = '0;

    always #5 clk = ~clk;

    wb_spi_mailbox #(.DEPTH(DEPTH), .ID_VALUE(ID), .WAIT_STATES(0)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_adr_i(adr[0]),
        .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .soft_reset(soft_reset), .start_pulse(start_pulse), .irq(irq)
    );

    wb_spi_mailbox #(.DEPTH(DEPTH), .ID_VALUE(ID), .WAIT_STATES(2)) dut_ws (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_adr_i(adr[1]),
        .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
        .tx_tvalid(tx_tvalid_b), .tx_tready(tx_tready_b), .tx_tdata(tx_tdata_b),
        .rx_tvalid(rx_tvalid_b), .rx_tready(rx_tready_b), .rx_tdata(rx_tdata_b),
        .soft_reset(soft_reset_b), .start_pulse(start_pulse_b), .irq(irq_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic        irq_en_m = 1'b0, tx_ovf_m = 1'b0, rx_ovf_m = 1'b0, lb_m = 1'b0;
    logic [31:0] scratch_m = '0;
    int          exp_sr = 0, exp_sp = 0, sr_seen = 0, sp_seen = 0, bad_idle = 0;
    int          ack_seen[2] = '{0, 0};
    int          xfer_done[2] = '{0, 0};
    logic        mon_en = 1'b0;
    logic        req_pending = 1'b0;
    logic        req_we;
    logic [25:0] req_adr;
    logic [31:0] req_dat, exp_rd;
    logic        rand_en = 1'b0;

    // Observers that run every cycle regardless of the model
    always @(negedge clk) begin
        if (!rst) begin
            if (ack[0]) ack_seen[0]++;
            if (ack[1]) ack_seen[1]++;
            if (!ack[0] && rdat[0] != 0) bad_idle++;
            if (!ack[1] && rdat[1] != 0) bad_idle++;
            if (soft_reset)  sr_seen++;
            if (start_pulse) sp_seen++;
        end
    end

    // Model: compare stream outputs, then apply what the coming edge will do
    always @(negedge clk) begin
        int unsigned ntx, nrx;
        logic        txp, rxp, mv;
        logic [31:0] rx_in;
        logic [5:0]  ridx;
        if (mon_en) begin
            ntx = txq.size();
            nrx = rxq.size();
            check("tx_tvalid", 32'(tx_tvalid), 32'(!lb_m && ntx != 0));
            check("rx_tready", 32'(rx_tready), 32'(!lb_m && nrx < DEPTH));
            check("irq", 32'(irq), 32'(irq_en_m && (nrx != 0 || tx_ovf_m || rx_ovf_m)));
            if (!lb_m && ntx != 0) check("tx_tdata", tx_tdata, txq[0]);
            mv    = lb_m && ntx != 0 && nrx < DEPTH;
            txp   = mv || (!lb_m && ntx != 0 && tx_tready);
            rxp   = mv || (!lb_m && nrx < DEPTH && rx_tvalid);
            rx_in = mv ? txq[0] : rx_tdata;
            if (req_pending) begin
                req_pending = 1'b0;
                ridx = req_adr[7:2];
                case (ridx)
                    6'd0: exp_rd = ID;
                    6'd1: exp_rd = {28'b0, lb_m, irq_en_m, 2'b00};
                    6'd2: exp_rd = {8'(ntx), 8'(nrx), 12'h000, rx_ovf_m, tx_ovf_m, nrx != 0, ntx == DEPTH};
                    6'd3: exp_rd = scratch_m;
                    6'd4: exp_rd = '0;
                    6'd5: exp_rd = (nrx != 0) ? rxq[0] : '0;
                    default: exp_rd = 32'hDEAD_BEEF;
                endcase
                if (req_we) begin
                    case (ridx)
                        6'd1: begin
                            exp_sr  += int'(req_dat[0]);
                            exp_sp  += int'(req_dat[1]);
                            irq_en_m = req_dat[2];
`ifdef WB_SPI_MAILBOX_LOOPBACK_EN
                            lb_m = req_dat[3];
`endif
                        end
                        6'd2: begin
                            if (req_dat[3]) rx_ovf_m = 1'b0;
                            if (req_dat[2]) tx_ovf_m = 1'b0;
                        end
                        6'd3: scratch_m = req_dat;
                        6'd4: if (ntx < DEPTH || txp) txq.push_back(req_dat); else tx_ovf_m = 1'b1;
                        default: ;
                    endcase
                end else if (ridx == 6'd5) begin
                    if (nrx != 0) void'(rxq.pop_front()); else rx_ovf_m = 1'b1;
                end
            end
            if (txp) void'(txq.pop_front());
            if (rxp) rxq.push_back(rx_in);
        end
    end

    task automatic wb_xfer(input int sel, input logic w, input logic [25:0] a,
                           input logic [31:0] d, output logic [31:0] r, output int lat);
        @(posedge clk); #1;
        cyc[sel] = 1'b1; stb[sel] = 1'b1; we[sel] = w; adr[sel] = a; wdat[sel] = d;
        if (sel == 0) begin
            req_we = w; req_adr = a; req_dat = d; req_pending = 1'b1;
        end
        lat = 0;
        r   = '0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[sel] && lat < 20);
        if (ack[sel]) begin
            r = rdat[sel];
            xfer_done[sel]++;
        end else begin
            check("ack_timeout", 32'(ack[sel]), 32'd1);
        end
        // keep stb up through the whole ack cycle
        @(posedge clk); #1;
        cyc[sel] = 1'b0; stb[sel] = 1'b0; we[sel] = 1'b0;
    endtask

    task automatic bus(input string tag, input logic w, input logic [7:0] off,
                       input logic [31:0] d, output logic [31:0] r);
        int          lat;
        logic [25:0] a;
        a = {18'($urandom), off[7:2], 2'($urandom)};
        wb_xfer(0, w, a, d, r, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        if (!w) check(tag, r, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] words[3];
        int          lat, s0, p0, a0;
        logic [7:0]  off;
        logic [31:0] d;
        logic        w;

        for (int unsigned i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdat[i] = '0;
        end
        tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_dat", rdat[0], 32'd0);
        check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_soft_reset", 32'(soft_reset), 32'd0);
        check("rst_start", 32'(start_pulse), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rx_tready", 32'(rx_tready), 32'd1);
        mon_en = 1'b1;

        // ID read, single ack with stb held through the ack cycle
        bus("id", 1'b0, 8'h00, '0, r);
        check("id_const", r, ID);
        repeat (4) @(negedge clk);
        check("one_ack", 32'(ack_seen[0]), 32'(xfer_done[0]));

        // Scratch and unmapped
        bus("scr_wr", 1'b1, 8'h0C, 32'hA5A5_0F0F, r);
        bus("scr_rd", 1'b0, 8'h0C, '0, r);
        check("scr_const", r, 32'hA5A5_0F0F);
        bus("unmapped", 1'b0, 8'h40, '0, r);
        check("unmapped_const", r, 32'hDEAD_BEEF);
        bus("id_wr", 1'b1, 8'h00, 32'h1, r);
        bus("id_rd2", 1'b0, 8'h00, '0, r);

        // CTRL pulses
        s0 = sr_seen; p0 = sp_seen;
        bus("ctrl_wr", 1'b1, 8'h04, 32'h3, r);
        repeat (3) @(negedge clk);
        check("soft_reset_pulse", 32'(sr_seen - s0), 32'd1);
        check("start_pulse", 32'(sp_seen - p0), 32'd1);

        // TX overflow with stalled stream, then drain in order
        for (int unsigned i = 0; i < 9; i++)
            bus("tx_push", 1'b1, 8'h10, $urandom, r);
        bus("st_full", 1'b0, 8'h08, '0, r);
        check("st_tx_cnt", 32'(r[31:24]), 32'd8);
        check("st_tx_full", 32'(r[0]), 32'd1);
        check("st_tx_ovf", 32'(r[2]), 32'd1);
        @(posedge clk); #1 tx_tready = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_tready = 1'b0;
        bus("w1c_tx", 1'b1, 8'h08, 32'h4, r);
        bus("st_clr", 1'b0, 8'h08, '0, r);
        check("st_tx_ovf_clr", 32'(r[2]), 32'd0);
        check("st_tx_empty", 32'(r[31:24]), 32'd0);

        // RX stream push, irq, pops and underflow
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            words[i]  = $urandom;
            rx_tvalid = 1'b1;
            rx_tdata  = words[i];
        end
        @(posedge clk); #1 rx_tvalid = 1'b0;
        bus("irq_en", 1'b1, 8'h04, 32'h4, r);
        @(negedge clk);
        check("irq_on", 32'(irq), 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            bus("rx_pop", 1'b0, 8'h14, '0, r);
            check("rx_word", r, words[i]);
        end
        bus("rx_under", 1'b0, 8'h14, '0, r);
        check("rx_under_zero", r, 32'd0);
        bus("st_rxovf", 1'b0, 8'h08, '0, r);
        check("st_rx_ovf", 32'(r[3]), 32'd1);
        bus("w1c_all", 1'b1, 8'h08, 32'hC, r);
        bus("ctrl_off", 1'b1, 8'h04, 32'h0, r);

        // Wait-state instance: latency, abort, normal access afterwards
        wb_xfer(1, 1'b0, 26'h0, '0, r, lat);
        check("ws_lat", 32'(lat), 32'd3);
        check("ws_id", r, ID);
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 26'h0;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        a0 = ack_seen[1];
        repeat (6) @(negedge clk);
        check("ws_abort_noack", 32'(ack_seen[1] - a0), 32'd0);
        wb_xfer(1, 1'b1, 26'h0C, 32'h0000_0077, r, lat);
        wb_xfer(1, 1'b0, 26'h0C, '0, r, lat);
        check("ws_lat2", 32'(lat), 32'd3);
        check("ws_scratch", r, 32'h0000_0077);

        // Randomized traffic with random stream activity
        rand_en = 1'b1;
        fork
            while (rand_en) begin
                @(posedge clk); #1;
                tx_tready = 1'($urandom_range(0, 1));
                rx_tvalid = ($urandom_range(0, 3) == 0);
                rx_tdata  = $urandom;
            end
        join_none
        for (int unsigned n = 0; n < 300; n++) begin
            w   = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 7) == 0) ? 8'(4 * $urandom_range(6, 63)) : 8'(4 * $urandom_range(0, 5));
            d   = $urandom;
            if (off == 8'h04) d[3] = 1'b0;
            bus("rand", w, off, d, r);
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        tx_tready = 1'b0;
        rx_tvalid = 1'b0;

`ifdef WB_SPI_MAILBOX_LOOPBACK_EN
        tx_tready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1 tx_tready = 1'b0;
        for (int unsigned i = 0; i < 2 * DEPTH && rxq.size() != 0; i++)
            bus("lb_drain", 1'b0, 8'h14, '0, r);
        bus("lb_ctrl", 1'b1, 8'h04, 32'h8, r);
        bus("lb_ctrl_rd", 1'b0, 8'h04, '0, r);
        bus("lb_push", 1'b1, 8'h10, 32'h1234, r);
        repeat (4) @(posedge clk);
        bus("lb_read", 1'b0, 8'h14, '0, r);
        check("lb_data", r, 32'h1234);
        bus("lb_off", 1'b1, 8'h04, 32'h0, r);
`endif

        repeat (4) @(negedge clk);
        check("acks_0", 32'(ack_seen[0]), 32'(xfer_done[0]));
        check("acks_1", 32'(ack_seen[1]), 32'(xfer_done[1]));
        check("soft_reset_total", 32'(sr_seen), 32'(exp_sr));
        check("start_total", 32'(sp_seen), 32'(exp_sp));
        check("dat_idle_zero", 32'(bad_idle), 32'd0);
        check("ws_tx_tvalid", 32'(tx_tvalid_b), 32'd0);
        check("ws_rx_tready", 32'(rx_tready_b), 32'd1);
        check("ws_quiet", 32'({soft_reset_b, start_pulse_b, irq_b}), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_spi_mailbox.md
WB_SPI_MAILBOX -- requirements
Module: wb_spi_mailbox

Interface
REQ-001 Parameter: DEPTH, 8, entries per FIFO (power of 2, 4..64).
REQ-002 Parameter: ID_VALUE, 32'h5350_4D42, constant returned by ID register.
REQ-003 Parameter: WAIT_STATES, 0, extra ack delay cycles (0..3).
REQ-004 Port: clk  in  1  clock; all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave controls.
REQ-007 Ports: wb_adr_i in 26 (byte address); wb_dat_i in 32; wb_dat_o out 32; wb_ack_o out 1.
REQ-008 Ports: tx_tvalid out 1, tx_tready in 1, tx_tdata out 32  stream toward local logic.
REQ-009 Ports: rx_tvalid in 1, rx_tready out 1, rx_tdata in 32  stream from local logic.
REQ-010 Ports: soft_reset out 1 (one-cycle pulse); start_pulse out 1 (one-cycle pulse); irq out 1 (level).

Function
REQ-011 Request accepted when wb_cyc_i & wb_stb_i & FSM in IDLE; stb remaining high in the ack cycle or after it shall not start a second access.
REQ-012 FSM states: IDLE -> WAIT (WAIT_STATES>0, counter loaded) -> ACK -> IDLE; with WAIT_STATES=0 IDLE -> ACK directly.
REQ-013 wb_ack_o high exactly one cycle per accepted request, registered, WAIT_STATES+1 cycles after accept; wb_dat_o valid in that cycle, 0 otherwise.
REQ-014 wb_cyc_i dropping before ack aborts: FSM returns to IDLE next cycle, no ack, no side effect not already committed at accept.
REQ-015 Decode wb_adr_i[7:2]; bits [25:8] and [1:0] ignored (256-byte aliasing).
REQ-016 0x00 ID: RO, ID_VALUE; writes ignored.
REQ-017 0x04 CTRL: write bit0=1 pulses soft_reset, bit1=1 pulses start_pulse, bit2 stores irq_en; read {29'b0, irq_en, 2'b00}.
REQ-018 0x08 STATUS: read {tx_cnt[7:0], rx_cnt[7:0], 12'b0, rx_ovf, tx_ovf, rx_nonempty, tx_full}; write 1 to bit3/bit2 clears rx_ovf/tx_ovf.
REQ-019 0x0C SCRATCH: RW 32 bits.
REQ-020 0x10 TXDATA: write pushes wb_dat_i to TX FIFO; if full, data dropped and tx_ovf set; read returns 0.
REQ-021 0x14 RXDATA: read pops RX FIFO head; empty read returns 32'h0 and sets rx_ovf (underflow); writes ignored.
REQ-022 Unmapped offsets (0x18..0xFC): read 32'hDEAD_BEEF, writes ignored, acked normally.
REQ-023 Side effects (push, pop, pulses, W1C) commit in the accept cycle; read data captured then.
REQ-024 tx_tvalid = TX FIFO not empty; tx_tdata = head; pop on tx_tvalid & tx_tready; rx_tready = RX FIFO not full.
REQ-025 Simultaneous push and pop on a FIFO: count unchanged, both complete; push while full plus pop same cycle is accepted.
REQ-026 Counts 0..DEPTH, zero-extended to 8 bits; pointers wrap modulo DEPTH.
REQ-027 irq = irq_en & (rx_nonempty | tx_ovf | rx_ovf).

Reset
REQ-028 rst clears FSM to IDLE, FIFOs empty, pointers 0, SCRATCH 0, irq_en 0, flags 0; wb_ack_o, wb_dat_o, tx_tvalid, soft_reset, start_pulse, irq all 0; rx_tready 1 from first cycle after reset.
REQ-029 rst mid-access drops the pending ack; soft_reset pulse does not reset this block.

Configuration
REQ-030 Macro WB_SPI_MAILBOX_LOOPBACK_EN: when defined, CTRL bit3 (RW) = loopback; when set, TX FIFO head pops into RX FIFO when RX not full, tx_tvalid forced 0, rx_tdata/rx_tvalid ignored, rx_tready 0.
REQ-031 Without the macro, CTRL bit3 reads 0, writes ignored, no loopback logic.

Verification
REQ-032 After reset, read 0x00 -> ack 1 cycle after accept, data 32'h5350_4D42; stb held through ack -> only one ack.
REQ-033 Write 0x0C=32'hA5A5_0F0F, read 0x0C -> 32'hA5A5_0F0F; read 0x40 -> 32'hDEAD_BEEF.
REQ-034 tx_tready=0, 9 writes to 0x10 with DEPTH=8 -> STATUS = tx_cnt 8, tx_full 1, tx_ovf 1; tx_tready=1 -> 8 words out in order; W1C bit2 -> tx_ovf 0.
REQ-035 Push 3 words via rx stream; irq_en=1 -> irq 1; 3 reads of 0x14 return them in order, 4th returns 0 with rx_ovf 1.
REQ-036 WAIT_STATES=2: ack 3 cycles after accept; cyc dropped 1 cycle after accept -> no ack, next access normal.
REQ-037 Write CTRL=32'h3 -> soft_reset and start_pulse each high exactly one cycle; loopback build: CTRL bit3=1, write 0x10=32'h1234 -> read 0x14 returns 32'h1234.
